// File: rtl/fitness_dispatcher_pkg.sv
// Shared GA package: fitness unit state encoding and round-robin helpers.
package fitness_dispatcher_pkg;

    typedef enum logic [1:0] {
        UNIT_IDLE = 2'd0,
        UNIT_RUN  = 2'd1,
        UNIT_DONE = 2'd2
    } unit_state_e;

    localparam int unsigned MaxUnits = 8;

    // First set bit of mask at or after ptr, wrapping modulo n (n <= MaxUnits).
    function automatic logic [2:0] rr_pick(input logic [7:0] mask,
                                           input logic [2:0] ptr,
                                           input int unsigned n);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MaxUnits; i++) begin
            if (i < n) begin
                idx = 32'(ptr) + i;
                if (idx >= n) idx = idx - n;
                if (!found && mask[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int unsigned n);
        if (32'(idx) + 32'd1 >= n) return 3'd0;
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/fitness_dispatch_slot.sv
// One fitness unit slot: IDLE/RUN/DONE state plus individual, tag and error registers.
module fitness_dispatch_slot
    import fitness_dispatcher_pkg::*;
#(
    parameter int unsigned IndividualWidth = 64,
    parameter int unsigned ErrorWidth      = 5,
    parameter int unsigned TagWidth        = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dispatch,
    input  logic [IndividualWidth-1:0] individual_in,
    input  logic [TagWidth-1:0]        tag_in,
    input  logic                       finish,
    input  logic [ErrorWidth-1:0]      error_in,
    input  logic                       accept,
    output unit_state_e                state,
    output logic                       start,
    output logic [IndividualWidth-1:0] individual,
    output logic [TagWidth-1:0]        tag,
    output logic [ErrorWidth-1:0]      error
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= UNIT_IDLE;
            start      <= 1'b0;
            individual <= '0;
            tag        <= '0;
            error      <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                UNIT_IDLE: if (dispatch) begin
                    state      <= UNIT_RUN;
                    start      <= 1'b1;
                    individual <= individual_in;
                    tag        <= tag_in;
                end
                UNIT_RUN: if (finish) begin
                    state <= UNIT_DONE;
                    error <= error_in;
                end
                UNIT_DONE: if (accept) state <= UNIT_IDLE;
                default: state <= UNIT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fitness_dispatcher.sv
// Round-robin dispatch of GA individuals onto a pool of fitness units with a
// round-robin result arbiter. Optional counters under FITNESS_DISPATCHER_STATS_EN.
module fitness_dispatcher
    import fitness_dispatcher_pkg::*;
#(
    parameter int unsigned IndividualWidth = 64,
    parameter int unsigned ErrorWidth      = 5,
    parameter int unsigned Units           = 2,
    parameter int unsigned TagWidth        = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [IndividualWidth-1:0]       req_individual,
    input  logic [TagWidth-1:0]              req_tag,
    output logic [Units-1:0]                 unit_start,
    output logic [Units*IndividualWidth-1:0] unit_individual,
    input  logic [Units-1:0]                 unit_finish,
    input  logic [Units*ErrorWidth-1:0]      unit_error,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [ErrorWidth-1:0]            res_error,
    output logic [TagWidth-1:0]              res_tag,
    output logic                             busy
`ifdef FITNESS_DISPATCHER_STATS_EN
    ,
    output logic [31:0]                      eval_count,
    output logic [31:0]                      stall_count
`endif
);

    logic [Units-1:0]      idle_mask;
    logic [Units-1:0]      done_mask;
    logic [Units-1:0]      dispatch_vec;
    logic [Units-1:0]      accept_vec;
    unit_state_e           slot_state [Units];
    logic [TagWidth-1:0]   slot_tag   [Units];
    logic [ErrorWidth-1:0] slot_error [Units];

    logic [2:0] dispatch_ptr;
    logic [2:0] result_ptr;
    logic [2:0] disp_sel;
    logic [2:0] res_sel;
    logic [2:0] res_sel_q;
    logic       res_lock;
    logic [7:0] idle8;
    logic [7:0] done8;
    logic       req_fire;
    logic       res_fire;

    for (genvar g = 0; g < Units; g++) begin : g_slot
        fitness_dispatch_slot #(
            .IndividualWidth(IndividualWidth),
            .ErrorWidth     (ErrorWidth),
            .TagWidth       (TagWidth)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .dispatch     (dispatch_vec[g]),
            .individual_in(req_individual),
            .tag_in       (req_tag),
            .finish       (unit_finish[g]),
            .error_in     (unit_error[g*ErrorWidth +: ErrorWidth]),
            .accept       (accept_vec[g]),
            .state        (slot_state[g]),
            .start        (unit_start[g]),
            .individual   (unit_individual[g*IndividualWidth +: IndividualWidth]),
            .tag          (slot_tag[g]),
            .error        (slot_error[g])
        );
        assign idle_mask[g] = (slot_state[g] == UNIT_IDLE);
        assign done_mask[g] = (slot_state[g] == UNIT_DONE);
    end

    // Ready and valid come from registered slot state only.
    assign req_ready = |idle_mask;
    assign res_valid = |done_mask;
    assign busy      = ~&idle_mask;
    assign req_fire  = req_valid & req_ready;
    assign res_fire  = res_valid & res_ready;

    always_comb begin
        idle8                = '0;
        done8                = '0;
        idle8[Units-1:0]     = idle_mask;
        done8[Units-1:0]     = done_mask;
        disp_sel             = rr_pick(idle8, dispatch_ptr, Units);
        // A stalled result is locked so a later finish cannot displace it.
        res_sel              = res_lock ? res_sel_q : rr_pick(done8, result_ptr, Units);
        dispatch_vec         = '0;
        accept_vec           = '0;
        res_error            = '0;
        res_tag              = '0;
        for (int unsigned i = 0; i < Units; i++) begin
            if (disp_sel == i[2:0]) dispatch_vec[i] = req_fire;
            if (res_sel == i[2:0]) begin
                accept_vec[i] = res_fire;
                res_error     = slot_error[i];
                res_tag       = slot_tag[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dispatch_ptr <= '0;
            result_ptr   <= '0;
            res_sel_q    <= '0;
            res_lock     <= 1'b0;
        end else begin
            if (req_fire) dispatch_ptr <= rr_next(disp_sel, Units);
            if (res_fire) begin
                result_ptr <= rr_next(res_sel, Units);
                res_lock   <= 1'b0;
            end else if (res_valid) begin
                res_lock  <= 1'b1;
                res_sel_q <= res_sel;
            end
        end
    end

`ifdef FITNESS_DISPATCHER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eval_count  <= '0;
            stall_count <= '0;
        end else begin
            if (res_fire) eval_count <= eval_count + 32'd1;
            if (req_valid && !req_ready) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fitness_dispatcher.sv
// Directed plus randomized bench for fitness_dispatcher; emulates the fitness units.
module tb_fitness_dispatcher;

    localparam int unsigned IW = 64;
    localparam int unsigned EW = 5;
    localparam int unsigned U  = 2;
    localparam int unsigned TW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [IW-1:0]   req_individual = '0;
    logic [TW-1:0]   req_tag = '0;
    logic [U-1:0]    unit_start;
    logic [U*IW-1:0] unit_individual;
    logic [U-1:0]    unit_finish = '0;
    logic [U*EW-1:0] unit_error = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [EW-1:0]   res_error;
    logic [TW-1:0]   res_tag;
    logic            busy;
`ifdef FITNESS_DISPATCHER_STATS_EN
    logic [31:0]     eval_count;
    logic [31:0]     stall_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fitness_dispatcher #(
        .IndividualWidth(IW),
        .ErrorWidth     (EW),
        .Units          (U),
        .TagWidth       (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_individual (req_individual),
        .req_tag        (req_tag),
        .unit_start     (unit_start),
        .unit_individual(unit_individual),
        .unit_finish    (unit_finish),
        .unit_error     (unit_error),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_error      (res_error),
        .res_tag        (res_tag),
        .busy           (busy)
`ifdef FITNESS_DISPATCHER_STATS_EN
        ,
        .eval_count     (eval_count),
        .stall_count    (stall_count)
`endif
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    localparam logic [63:0] IND0 = 64'hA5A5_0000_FFFF_1234;
    localparam logic [63:0] IND1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] IND2 = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [63:0] IND3 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] IND4 = 64'hFEDC_BA98_7654_3210;

    // Randomized-phase model state
    int           cnt     [U];
    logic [EW-1:0] uerr   [U];
    logic [TW-1:0] mtag   [U];
    bit           done_tag [32];
    logic [EW-1:0] exp_err [32];
    logic [IW-1:0] last_ind;
    logic [TW-1:0] last_tag;
    logic [TW-1:0] next_tag;
    logic [TW-1:0] prev_tag;
    logic [EW-1:0] prev_err;
    bit           prev_hold;
    int           m_eval;
    int           m_stall;

    initial begin
        // Reset then idle
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_unit_start", 64'(unit_start), 64'd0);
        chk("rst_unit_ind0", unit_individual[63:0], 64'd0);
        rst = 1'b1;
        tick();
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        chk("rel_res_valid", 64'(res_valid), 64'd0);
        chk("rel_unit_start", 64'(unit_start), 64'd0);

        // Single request, unit 0 finishes five cycles later
        req_valid = 1'b1; req_individual = IND0; req_tag = 5'd7;
        tick();
        req_valid = 1'b0;
        chk("single_start", 64'(unit_start), 64'b01);
        chk("single_ind", unit_individual[63:0], IND0);
        chk("single_busy", 64'(busy), 64'd1);
        tick();
        chk("single_start_off", 64'(unit_start), 64'd0);
        repeat (3) tick();
        chk("single_no_res", 64'(res_valid), 64'd0);
        unit_finish = 2'b01; unit_error = {5'd0, 5'd3};
        tick();
        unit_finish = '0;
        chk("single_res_valid", 64'(res_valid), 64'd1);
        chk("single_res_tag", 64'(res_tag), 64'd7);
        chk("single_res_err", 64'(res_error), 64'd3);
        chk("single_ind_held", unit_individual[63:0], IND0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("single_drained", 64'(res_valid), 64'd0);
        chk("single_idle", 64'(busy), 64'd0);

        reset_dut();

        // Spurious finish on idle units
        unit_finish = 2'b11; unit_error = {5'd9, 5'd9};
        tick();
        unit_finish = '0;
        chk("spur_res_valid", 64'(res_valid), 64'd0);
        chk("spur_busy", 64'(busy), 64'd0);
        tick();
        chk("spur_res_valid2", 64'(res_valid), 64'd0);

        // Fill and stall
        req_valid = 1'b1; req_individual = IND1; req_tag = 5'd1;
        tick();
        chk("fill_start0", 64'(unit_start), 64'b01);
        chk("fill_ind0", unit_individual[63:0], IND1);
        req_individual = IND2; req_tag = 5'd2;
        tick();
        chk("fill_start1", 64'(unit_start), 64'b10);
        chk("fill_ind1", unit_individual[127:64], IND2);
        chk("fill_ind0_held", unit_individual[63:0], IND1);
        req_individual = IND3; req_tag = 5'd3;
        chk("fill_not_ready", 64'(req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_not_ready", 64'(req_ready), 64'd0);
            chk("stall_no_start", 64'(unit_start), 64'd0);
        end

        // Out-of-order completion: unit 1 first, result held while not ready
        unit_finish = 2'b10; unit_error = {5'd9, 5'd0};
        tick();
        unit_finish = '0;
        chk("ooo_valid", 64'(res_valid), 64'd1);
        chk("ooo_tag", 64'(res_tag), 64'd2);
        chk("ooo_err", 64'(res_error), 64'd9);
        unit_finish = 2'b01; unit_error = {5'd0, 5'd4};
        for (int k = 0; k < 4; k++) begin
            tick();
            unit_finish = '0;
            chk("hold_tag", 64'(res_tag), 64'd2);
            chk("hold_err", 64'(res_error), 64'd9);
            chk("hold_not_ready", 64'(req_ready), 64'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("freed_ready", 64'(req_ready), 64'd1);
        chk("freed_no_same_cycle", 64'(unit_start), 64'd0);
        chk("next_res_tag", 64'(res_tag), 64'd1);
        chk("next_res_err", 64'(res_error), 64'd4);
        tick();
        req_valid = 1'b0;
        chk("tag3_start", 64'(unit_start), 64'b10);
        chk("tag3_ind", unit_individual[127:64], IND3);
        chk("tag3_not_ready", 64'(req_ready), 64'd0);

        // Simultaneous accept (unit 0), finish (unit 1) and request
        res_ready = 1'b1;
        unit_finish = 2'b10; unit_error = {5'd17, 5'd0};
        req_valid = 1'b1; req_individual = IND4; req_tag = 5'd4;
        tick();
        res_ready = 1'b0;
        chk("sim_res_valid", 64'(res_valid), 64'd1);
        chk("sim_res_tag", 64'(res_tag), 64'd3);
        chk("sim_res_err", 64'(res_error), 64'd17);
        chk("sim_ready", 64'(req_ready), 64'd1);
        chk("sim_no_start", 64'(unit_start), 64'd0);
        unit_finish = 2'b10; unit_error = {5'd1, 5'd0};
        tick();
        unit_finish = '0;
        req_valid = 1'b0;
        chk("sim_start0", 64'(unit_start), 64'b01);
        chk("sim_ind0", unit_individual[63:0], IND4);
        chk("done_finish_ignored", 64'(res_error), 64'd17);
        chk("done_tag_kept", 64'(res_tag), 64'd3);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("drain_valid0", 64'(res_valid), 64'd0);
        chk("drain_busy", 64'(busy), 64'd1);
        unit_finish = 2'b01; unit_error = {5'd0, 5'd5};
        tick();
        unit_finish = '0;
        chk("last_tag", 64'(res_tag), 64'd4);
        chk("last_err", 64'(res_error), 64'd5);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("all_idle_valid", 64'(res_valid), 64'd0);
        chk("all_idle_busy", 64'(busy), 64'd0);
`ifdef FITNESS_DISPATCHER_STATS_EN
        chk("eval_count_4", 64'(eval_count), 64'd4);
        chk("stall_count_10", 64'(stall_count), 64'd10);
`endif

        // Mid-run asynchronous reset
        req_valid = 1'b1; req_individual = IND2; req_tag = 5'd9;
        tick();
        req_valid = 1'b0;
        tick();
        chk("midrun_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_res_valid", 64'(res_valid), 64'd0);
        chk("arst_unit_start", 64'(unit_start), 64'd0);
        chk("arst_ind0", unit_individual[63:0], 64'd0);
        chk("arst_ind1", unit_individual[127:64], 64'd0);
        chk("arst_res_tag", 64'(res_tag), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd1);
`ifdef FITNESS_DISPATCHER_STATS_EN
        chk("arst_eval", 64'(eval_count), 64'd0);
        chk("arst_stall", 64'(stall_count), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Randomized phase with emulated fitness units
        for (int i = 0; i < int'(U); i++) cnt[i] = 0;
        for (int t = 0; t < 32; t++) done_tag[t] = 1'b0;
        next_tag  = '0;
        last_ind  = '0;
        last_tag  = '0;
        prev_hold = 1'b0;
        prev_tag  = '0;
        prev_err  = '0;
        m_eval    = 0;
        m_stall   = 0;
        for (int cyc = 0; cyc < 440; cyc++) begin
            tick();
            for (int i = 0; i < int'(U); i++) begin
                if (unit_start[i]) begin
                    chk("rand_start_ind", unit_individual[i*IW +: IW], last_ind);
                    mtag[i] = last_tag;
                    cnt[i]  = int'($urandom_range(1, 6));
                    uerr[i] = EW'($urandom);
                end
            end
            unit_finish = '0;
            for (int i = 0; i < int'(U); i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        unit_finish[i]             = 1'b1;
                        unit_error[i*EW +: EW]     = uerr[i];
                        exp_err[mtag[i]]           = uerr[i];
                        done_tag[mtag[i]]          = 1'b1;
                    end
                end
            end
            if (res_valid) begin
                chk("rand_res_known", 64'(done_tag[res_tag]), 64'd1);
                chk("rand_res_err", 64'(res_error), 64'(exp_err[res_tag]));
                if (prev_hold) begin
                    chk("rand_hold_tag", 64'(res_tag), 64'(prev_tag));
                    chk("rand_hold_err", 64'(res_error), 64'(prev_err));
                end
            end
            res_ready = ($urandom_range(0, 3) != 0) || (cyc >= 400);
            prev_hold = res_valid && !res_ready;
            prev_tag  = res_tag;
            prev_err  = res_error;
            if (res_valid && res_ready) begin
                done_tag[res_tag] = 1'b0;
                m_eval++;
            end
            req_valid      = (cyc < 400) && ($urandom_range(0, 1) == 1);
            req_individual = {$urandom, $urandom};
            req_tag        = next_tag;
            if (req_valid && req_ready) begin
                last_ind = req_individual;
                last_tag = next_tag;
                next_tag = next_tag + 5'd1;
            end
            if (req_valid && !req_ready) m_stall++;
        end
        tick();
        req_valid = 1'b0;
        res_ready = 1'b0;
        unit_finish = '0;
        chk("rand_end_busy", 64'(busy), 64'd0);
        chk("rand_end_valid", 64'(res_valid), 64'd0);
        chk("rand_some_evals", 64'(m_eval > 20), 64'd1);
`ifdef FITNESS_DISPATCHER_STATS_EN
        chk("rand_eval_count", 64'(eval_count), 64'(m_eval));
        chk("rand_stall_count", 64'(stall_count), 64'(m_stall));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
